rom_port_arbiter: RTL and testbench

- Shares the single genrom read port (addr/extra/bounds in; data/error out) between two requesters: port 0 = cpu instruction/data fetch, port 1 = host/debug loader.
- Round-robin arbitration, one outstanding access, registered grant, per-requester bounds window applied to the ROM on each access.
- Sits between cpu/host and genrom in the SoC top and in cpu benches that need a host-side ROM reader.

---
 rtl/rom_port_arbiter_pkg.sv | 18 +
 rtl/rom_port_arbiter_rr.sv | 33 +++
 rtl/rom_port_arbiter.sv | 116 +++++++++++
 tb/tb_rom_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the two-port genrom arbiter: FSM state encodings,
// requester port indices and a one-hot helper.
package rom_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  function automatic logic [1:0] portOneHot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr.sv
// Two-way round-robin pick: the port granted last loses a simultaneous request;
// after reset the cpu port has priority.
module rr_arbiter2
  import rom_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_winner,
  output logic       o_any
);

  logic r_last;

  always_comb begin
    o_any = |i_req;
    if (i_req == 2'b11) begin
      o_winner = ~r_last;
    end else begin
      o_winner = i_req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PORT_HOST;
    end else if (i_update && o_any) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the genrom read port between the cpu (port 0) and host loader (port 1):
// round-robin pick, one outstanding access, registered grant and response strobes.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter  int MEM_ADDR  = 6,
  parameter  int MEM_EXTRA = 4,
  localparam int AW        = MEM_ADDR + 1,
  localparam int DW        = (2 ** MEM_EXTRA) * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [MEM_EXTRA-1:0] cpu_extra,
  input  logic [AW-1:0]        cpu_lower,
  input  logic [AW-1:0]        cpu_upper,
  output logic                 cpu_gnt,
  output logic                 cpu_rsp_valid,
  input  logic                 host_req,
  input  logic [AW-1:0]        host_addr,
  input  logic [MEM_EXTRA-1:0] host_extra,
  input  logic [AW-1:0]        host_lower,
  input  logic [AW-1:0]        host_upper,
  output logic                 host_gnt,
  output logic                 host_rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_error,
  output logic [AW-1:0]        mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  output logic [AW-1:0]        mem_lower,
  output logic [AW-1:0]        mem_upper,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error
);

  arb_state_t           r_state;
  logic [1:0]           r_gnt;
  logic [1:0]           r_rspValid;
  logic                 r_owner;
  logic [AW-1:0]        r_memAddr;
  logic [MEM_EXTRA-1:0] r_memExtra;
  logic [AW-1:0]        r_memLower;
  logic [AW-1:0]        r_memUpper;

  logic w_arbEdge;
  logic w_winner;
  logic w_any;

  assign w_arbEdge = (r_state == ARB_IDLE) || (r_state == ARB_DONE);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({host_req, cpu_req}),
    .i_update (w_arbEdge),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // DONE re-arbitrates directly, so a held request sees one access per two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= 2'b00;
      r_rspValid <= 2'b00;
      r_owner    <= PORT_CPU;
      r_memAddr  <= '0;
      r_memExtra <= '0;
      r_memLower <= '0;
      r_memUpper <= '1;
    end else begin
      r_gnt      <= 2'b00;
      r_rspValid <= 2'b00;
      case (r_state)
        ARB_IDLE, ARB_DONE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_gnt   <= portOneHot(w_winner);
            r_state <= ARB_WAIT;
            if (w_winner == PORT_HOST) begin
              r_memAddr  <= host_addr;
              r_memExtra <= host_extra;
              r_memLower <= host_lower;
              r_memUpper <= host_upper;
            end else begin
              r_memAddr  <= cpu_addr;
              r_memExtra <= cpu_extra;
              r_memLower <= cpu_lower;
              r_memUpper <= cpu_upper;
            end
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_WAIT: begin
          r_rspValid <= portOneHot(r_owner);
          r_state    <= ARB_DONE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign cpu_gnt        = r_gnt[0];
  assign host_gnt       = r_gnt[1];
  assign cpu_rsp_valid  = r_rspValid[0];
  assign host_rsp_valid = r_rspValid[1];
  assign rsp_data       = mem_data;
  assign rsp_error      = mem_error;
  assign mem_addr       = r_memAddr;
  assign mem_extra      = r_memExtra;
  assign mem_lower      = r_memLower;
  assign mem_upper      = r_memUpper;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a registered genrom stand-in
// holding byte[i]=i; requesters push expectations when granted.
module tb_rom_port_arbiter;

  localparam int AW = 7;
  localparam int EW = 4;
  localparam int DW = 128;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, host_req;
  logic [AW-1:0] cpu_addr, cpu_lower, cpu_upper;
  logic [AW-1:0] host_addr, host_lower, host_upper;
  logic [EW-1:0] cpu_extra, host_extra;
  logic          cpu_gnt, host_gnt, cpu_rsp_valid, host_rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic [AW-1:0] mem_addr, mem_lower, mem_upper;
  logic [EW-1:0] mem_extra;
  logic [DW-1:0] mem_data;
  logic          mem_error;

  int   tests  = 0;
  int   failed = 0;
  int   cycleCount = 0;
  exp_t cpuQ[$];
  exp_t hostQ[$];
  int   grantLog[$];
  int   grantCyc[$];
  logic [1:0] prevGnt = 2'b00;
  logic [1:0] prevReq = 2'b00;
  logic       prevReset = 1'b1;
  logic [7:0] rom [0:127];

  always #5 clk = ~clk;

  rom_port_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_extra(cpu_extra),
    .cpu_lower(cpu_lower), .cpu_upper(cpu_upper),
    .cpu_gnt(cpu_gnt), .cpu_rsp_valid(cpu_rsp_valid),
    .host_req(host_req), .host_addr(host_addr), .host_extra(host_extra),
    .host_lower(host_lower), .host_upper(host_upper),
    .host_gnt(host_gnt), .host_rsp_valid(host_rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower(mem_lower), .mem_upper(mem_upper),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  function automatic logic [DW-1:0] romRead(input logic [AW-1:0] a, input logic [EW-1:0] x);
    logic [DW-1:0] d = '0;
    for (int k = 0; k < 16; k++)
      if (k <= int'(x)) d[k*8 +: 8] = rom[(int'(a) + k) % 128];
    return d;
  endfunction

  // genrom stand-in: data and bounds error appear one cycle after the address.
  always @(posedge clk) begin
    mem_data  <= romRead(mem_addr, mem_extra);
    mem_error <= (mem_addr < mem_lower) || (int'(mem_addr) + int'(mem_extra) > int'(mem_upper));
  end

  function automatic exp_t refModel(input int a, input int x, input int lo, input int up);
    exp_t e;
    e.data = '0;
    for (int k = 0; k <= x; k++) e.data[k*8 +: 8] = 8'(a + k);
    e.err = (a < lo) || (a + x > up);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: response timing against previous grant, protocol exclusivity, scoreboard pops.
  always @(negedge clk) begin
    logic [1:0] gnt, rsp, expRsp;
    exp_t e;
    cycleCount++;
    gnt    = {host_gnt, cpu_gnt};
    rsp    = {host_rsp_valid, cpu_rsp_valid};
    expRsp = prevReset ? 2'b00 : prevGnt;
    if (rsp != 2'b00 || expRsp != 2'b00) checkOutput("rsp_valid_timing", rsp, expRsp);
    if (gnt != 2'b00) begin
      checkOutput("gnt_onehot", $onehot(gnt), 1);
      checkOutput("gnt_to_requester", gnt & prevReq, gnt);
      checkOutput("gnt_rsp_exclusive", rsp, 0);
      grantLog.push_back(int'(host_gnt));
      grantCyc.push_back(cycleCount);
    end
    if (cpu_rsp_valid) begin
      if (cpuQ.size() == 0) checkOutput("cpu_unexpected_rsp", 1, 0);
      else begin
        e = cpuQ.pop_front();
        checkOutput("cpu_rsp_error", rsp_error, e.err);
        if (!e.err) checkOutput("cpu_rsp_data", rsp_data, e.data);
      end
    end
    if (host_rsp_valid) begin
      if (hostQ.size() == 0) checkOutput("host_unexpected_rsp", 1, 0);
      else begin
        e = hostQ.pop_front();
        checkOutput("host_rsp_error", rsp_error, e.err);
        if (!e.err) checkOutput("host_rsp_data", rsp_data, e.data);
      end
    end
    prevGnt   = gnt;
    prevReq   = {host_req, cpu_req};
    prevReset = reset;
  end

  // Raise a request at a drive slot, wait for its grant, push the expectation.
  task automatic applyStimulus(input int p, input int a, input int x, input int lo, input int up,
                               input bit keep, output int waited);
    exp_t e;
    bit   got = 0;
    waited = 0;
    if (p == 0) begin
      cpu_addr = AW'(a); cpu_extra = EW'(x); cpu_lower = AW'(lo); cpu_upper = AW'(up); cpu_req = 1'b1;
    end else begin
      host_addr = AW'(a); host_extra = EW'(x); host_lower = AW'(lo); host_upper = AW'(up); host_req = 1'b1;
    end
    e = refModel(a, x, lo, up);
    while (!got && waited < 12) begin
      @(negedge clk);
      waited++;
      got = (p == 0) ? cpu_gnt : host_gnt;
    end
    if (!got) begin
      checkOutput($sformatf("gnt_timeout_port%0d", p), 0, 1);
    end else if (p == 0) cpuQ.push_back(e);
    else hostQ.push_back(e);
    @(posedge clk); #1;
    if (!keep || !got) begin
      if (p == 0) cpu_req = 1'b0; else host_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"}, {host_gnt, cpu_gnt}, 0);
    checkOutput({tag, "_rsp_valid"}, {host_rsp_valid, cpu_rsp_valid}, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_extra"}, mem_extra, 0);
    checkOutput({tag, "_mem_lower"}, mem_lower, 0);
    checkOutput({tag, "_mem_upper"}, mem_upper, 7'h7f);
  endtask

  task automatic applyReset();
    reset = 1'b1; cpu_req = 1'b0; host_req = 1'b0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    idle(1);
  endtask

  initial begin
    int w0, w1;
    for (int i = 0; i < 128; i++) rom[i] = 8'(i);
    reset = 1'b1;
    cpu_req = 0; cpu_addr = 0; cpu_extra = 0; cpu_lower = 0; cpu_upper = 0;
    host_req = 0; host_addr = 0; host_extra = 0; host_lower = 0; host_upper = 0;
    idle(3);
    applyReset();

    // Single cpu access: grant next cycle, response the one after.
    applyStimulus(0, 33, 0, 0, 127, 0, w0);
    checkOutput("cpu_latency", w0, 2);
    idle(2);

    // Simultaneous after reset: cpu first, host granted at cpu's DONE edge.
    applyReset();
    grantLog.delete();
    fork
      applyStimulus(0, 4, 0, 0, 127, 0, w0);
      applyStimulus(1, 8, 0, 0, 127, 0, w1);
    join
    checkOutput("pair1_count", grantLog.size(), 2);
    if (grantLog.size() == 2) begin
      checkOutput("pair1_first", grantLog[0], 0);
      checkOutput("pair1_second", grantLog[1], 1);
    end
    checkOutput("pair1_host_wait", w1, 4);
    idle(2);

    // After a cpu-only access, cpu has lowest priority on the next tie.
    applyStimulus(0, 5, 0, 0, 127, 0, w0);
    idle(2);
    grantLog.delete();
    fork
      applyStimulus(0, 6, 0, 0, 127, 0, w0);
      applyStimulus(1, 9, 0, 0, 127, 0, w1);
    join
    checkOutput("pair2_count", grantLog.size(), 2);
    if (grantLog.size() == 2) checkOutput("pair2_first", grantLog[0], 1);
    idle(2);

    // Held cpu request streams one access every two cycles.
    grantCyc.delete();
    applyStimulus(0, 0, 0, 0, 127, 1, w0);
    applyStimulus(0, 1, 0, 0, 127, 1, w0);
    applyStimulus(0, 2, 0, 0, 127, 0, w0);
    checkOutput("stream_count", grantCyc.size(), 3);
    if (grantCyc.size() == 3) begin
      checkOutput("stream_gap1", grantCyc[1] - grantCyc[0], 2);
      checkOutput("stream_gap2", grantCyc[2] - grantCyc[1], 2);
    end
    idle(2);

    // Host joins a cpu stream and must not starve.
    fork
      begin
        applyStimulus(0, 3, 0, 0, 127, 1, w0);
        applyStimulus(0, 4, 0, 0, 127, 1, w0);
        applyStimulus(0, 5, 0, 0, 127, 0, w0);
      end
      begin
        idle(3);
        applyStimulus(1, 60, 0, 0, 127, 0, w1);
        checkOutput("host_no_starve", w1 <= 3, 1);
      end
    join
    idle(2);

    // Bounds windows: host out of window errors, cpu full window reads.
    applyStimulus(1, 40, 0, 16, 31, 0, w1);
    applyStimulus(0, 40, 0, 0, 127, 0, w0);
    idle(2);

    // Reset during WAIT aborts the access with no response.
    cpu_addr = 20; cpu_extra = 0; cpu_lower = 0; cpu_upper = 127; cpu_req = 1'b1;
    idle(1);
    cpu_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_gnt_seen", cpu_gnt, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetState("rstwait");
    idle(1);
    applyStimulus(0, 7, 0, 0, 127, 0, w0);
    checkOutput("post_reset_latency", w0, 2);
    idle(2);

    // Multi-byte read, little-endian.
    applyStimulus(0, 10, 3, 0, 127, 0, w0);
    idle(2);

    // Randomized mix of single and simultaneous requests.
    for (int i = 0; i < 120; i++) begin
      int mode, a0, x0, l0, u0, a1, x1, l1, u1;
      mode = $urandom_range(0, 2);
      a0 = $urandom_range(0, 127); x0 = $urandom_range(0, 15);
      a1 = $urandom_range(0, 127); x1 = $urandom_range(0, 15);
      l0 = $urandom_range(0, 1) ? 0 : $urandom_range(0, 127);
      u0 = (l0 == 0) ? 127 : $urandom_range(l0, 127);
      l1 = $urandom_range(0, 1) ? 0 : $urandom_range(0, 127);
      u1 = (l1 == 0) ? 127 : $urandom_range(l1, 127);
      case (mode)
        0: applyStimulus(0, a0, x0, l0, u0, 0, w0);
        1: applyStimulus(1, a1, x1, l1, u1, 0, w1);
        default: fork
          applyStimulus(0, a0, x0, l0, u0, 0, w0);
          applyStimulus(1, a1, x1, l1, u1, 0, w1);
        join
      endcase
      idle($urandom_range(0, 2));
    end

    idle(4);
    checkOutput("cpuQ_drained", cpuQ.size(), 0);
    checkOutput("hostQ_drained", hostQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
